pipeline_uart_tx_scheduler: RTL and testbench

Shares the single UART transmitter between two byte producers. Requester 0 is the CPU memory-mapped TX register; requester 1 is the debug/echo path. Each requester has a small FIFO. A round-robin arbiter picks the next byte, and an FSM sequences the transmitter's TX_EN/TX_DATA/TX_STATUS handshake. TX_DATA is held stable for the whole frame, because the transmitter samples it live while shifting.

---
 rtl/pipeline_uart_tx_scheduler.sv | 194 +++++++++++++++++++
 tb/tb_pipeline_uart_tx_scheduler.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_uart_tx_scheduler.sv
// Two-requester byte scheduler in front of one UART transmitter: per-requester
// FIFOs, round-robin grant, and the TX_EN / TX_STATUS launch handshake.
module pipeline_uart_tx_scheduler #(
  parameter int DEPTH       = 4,
  parameter int ARM_TIMEOUT = 8,
  parameter int GAP_CYCLES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  input  logic       TX_STATUS,
  output logic       TX_EN,
  output logic [7:0] TX_DATA,
  output logic       busy,
  output logic       done_pulse,
  output logic       done_src,
  output logic       tx_err,
  input  logic       err_clr
);
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW   = PW + 1;
  localparam int TMAX = (ARM_TIMEOUT > GAP_CYCLES) ? ARM_TIMEOUT : GAP_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX + 1) : 1;
  localparam logic [CW-1:0] FULL    = CW'(DEPTH);
  localparam logic [TW-1:0] ARM_LIM = TW'(ARM_TIMEOUT);
  localparam logic [TW-1:0] GAP_LIM = TW'(GAP_CYCLES);

  typedef enum logic [2:0] {IDLE, LAUNCH, ARM, WAIT_DONE, GAP} state_t;
  localparam state_t AFTER_FRAME = (GAP_CYCLES == 0) ? IDLE : GAP;

  state_t        state_q, state_d;
  logic [7:0]    mem_q [2][DEPTH];
  logic [7:0]    mem_d [2][DEPTH];
  logic [PW-1:0] wptr_q [2];
  logic [PW-1:0] wptr_d [2];
  logic [PW-1:0] rptr_q [2];
  logic [PW-1:0] rptr_d [2];
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];
  logic [7:0]    in_data [2];
  logic [1:0]    in_valid, ready, push, pop, nonempty;
  logic          grant;
  logic          last_grant_q, last_grant_d;
  logic          src_q, src_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_en_q, tx_en_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          done_pulse_q, done_pulse_d;
  logic          done_src_q, done_src_d;
  logic          tx_err_q, tx_err_d;

  assign in_valid   = {req1_valid, req0_valid};
  assign in_data[0] = req0_data;
  assign in_data[1] = req1_data;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      ready[i]    = cnt_q[i] < FULL;
      nonempty[i] = cnt_q[i] != '0;
      push[i]     = in_valid[i] & ready[i];
    end
  end

  assign req0_ready = ready[0];
  assign req1_ready = ready[1];
  assign busy       = (state_q != IDLE) | (|nonempty);
  // Tie goes to whoever did not win last; last_grant resets to 1 so requester 0 wins first.
  assign grant      = (&nonempty) ? ~last_grant_q : nonempty[1];

  assign TX_EN      = tx_en_q;
  assign TX_DATA    = tx_data_q;
  assign done_pulse = done_pulse_q;
  assign done_src   = done_src_q;
  assign tx_err     = tx_err_q;

  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < 2; i++) begin
      wptr_d[i] = wptr_q[i];
      rptr_d[i] = rptr_q[i];
      cnt_d[i]  = cnt_q[i];
      if (push[i]) begin
        mem_d[i][wptr_q[i]] = in_data[i];
        wptr_d[i]           = wptr_q[i] + PW'(1);
      end
      if (pop[i]) rptr_d[i] = rptr_q[i] + PW'(1);
      case ({push[i], pop[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + CW'(1);
        2'b01:   cnt_d[i] = cnt_q[i] - CW'(1);
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    pop          = '0;
    last_grant_d = last_grant_q;
    src_d        = src_q;
    tx_data_d    = tx_data_q;
    tx_en_d      = 1'b0;
    timer_d      = timer_q;
    done_pulse_d = 1'b0;
    done_src_d   = done_src_q;
    tx_err_d     = err_clr ? 1'b0 : tx_err_q;
    case (state_q)
      IDLE: begin
        if (|nonempty) begin
          pop[grant]   = 1'b1;
          tx_data_d    = mem_q[grant][rptr_q[grant]];
          src_d        = grant;
          last_grant_d = grant;
          state_d      = LAUNCH;
        end
      end
      LAUNCH: begin
        tx_en_d = 1'b1;
        timer_d = '0;
        state_d = ARM;
      end
      ARM: begin
        if (!TX_STATUS) begin
          state_d = WAIT_DONE;
        end else begin
          timer_d = timer_q + TW'(1);
          // A timeout sets tx_err even when err_clr is asserted in the same cycle.
          if (timer_d == ARM_LIM) begin
            tx_err_d     = 1'b1;
            done_pulse_d = 1'b1;
            done_src_d   = src_q;
            timer_d      = '0;
            state_d      = AFTER_FRAME;
          end
        end
      end
      WAIT_DONE: begin
        if (TX_STATUS) begin
          done_pulse_d = 1'b1;
          done_src_d   = src_q;
          timer_d      = '0;
          state_d      = AFTER_FRAME;
        end
      end
      GAP: begin
        timer_d = timer_q + TW'(1);
        if (timer_d == GAP_LIM) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      for (int i = 0; i < 2; i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      last_grant_q <= 1'b1;
      src_q        <= 1'b0;
      tx_data_q    <= 8'h00;
      tx_en_q      <= 1'b0;
      timer_q      <= '0;
      done_pulse_q <= 1'b0;
      done_src_q   <= 1'b0;
      tx_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      src_q        <= src_d;
      tx_data_q    <= tx_data_d;
      tx_en_q      <= tx_en_d;
      timer_q      <= timer_d;
      done_pulse_q <= done_pulse_d;
      done_src_q   <= done_src_d;
      tx_err_q     <= tx_err_d;
    end
  end

  // FIFO storage carries no reset; occupancy is governed by the pointers and counts.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_pipeline_uart_tx_scheduler.sv
// Directed bench for pipeline_uart_tx_scheduler: table of single-frame vectors
// plus hand-written round-robin, full-FIFO and mid-frame reset sequences.
module tb_pipeline_uart_tx_scheduler;
  localparam int ARM_T = 8;
  localparam int GAP_C = 2;

  logic       clk = 1'b0;
  logic       reset, req0_valid, req1_valid, TX_STATUS, err_clr;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready, TX_EN, busy, done_pulse, done_src, tx_err;
  logic [7:0] TX_DATA;

  pipeline_uart_tx_scheduler #(.DEPTH(4), .ARM_TIMEOUT(ARM_T), .GAP_CYCLES(GAP_C)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .TX_STATUS(TX_STATUS), .TX_EN(TX_EN), .TX_DATA(TX_DATA), .busy(busy),
    .done_pulse(done_pulse), .done_src(done_src), .tx_err(tx_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit         model_on = 1'b0;
  int         frame_len = 40;
  int         en_cnt = 0;
  logic [7:0] en_q[$];
  int         en_cyc[$];
  int         dn_cyc[$];
  logic       dn_src[$];

  always @(negedge clk) begin
    if (!reset) begin
      if (TX_EN) begin
        en_cnt <= en_cnt + 1;
        en_q.push_back(TX_DATA);
        en_cyc.push_back(cyc);
      end
      if (done_pulse) begin
        dn_cyc.push_back(cyc);
        dn_src.push_back(done_src);
      end
    end
  end

  // Transmitter model: busy two cycles after the launch pulse, idle again frame_len cycles later.
  always begin
    @(posedge clk);
    #1;
    if (TX_EN && model_on && !reset) begin
      repeat (2) @(posedge clk);
      #1 TX_STATUS = 1'b0;
      repeat (frame_len) @(posedge clk);
      #1 TX_STATUS = 1'b1;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_done(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      tick(1);
      if (done_pulse) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  task automatic push(input bit r, input logic [7:0] d, input int lim, output bit ok);
    if (r) begin req1_valid = 1'b1; req1_data = d; end
    else   begin req0_valid = 1'b1; req0_data = d; end
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      if (r ? req1_ready : req0_ready) begin
        ok = 1'b1;
        tick(1);
        break;
      end
      tick(1);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  typedef struct {
    bit         src;
    logic [7:0] data;
    bit         tmo;
    bit         clr;
    bit         clr_hold;
    int         len;
    bit         exp_err;
  } vec_t;

  vec_t       tbl[6];
  logic [7:0] rr_exp[4];
  logic [7:0] ff_exp[8];
  bit         ok;
  int         c_en, en0, dn0;

  initial begin
    tbl[0] = '{1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 640, 1'b0};
    tbl[1] = '{1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 20,  1'b0};
    tbl[2] = '{1'b0, 8'h3C, 1'b1, 1'b0, 1'b0, 0,   1'b1};
    tbl[3] = '{1'b1, 8'hC3, 1'b0, 1'b1, 1'b0, 15,  1'b0};
    tbl[4] = '{1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 0,   1'b1};
    tbl[5] = '{1'b0, 8'h81, 1'b0, 1'b0, 1'b0, 12,  1'b1};
    rr_exp = '{8'h01, 8'h11, 8'h02, 8'h12};
    ff_exp = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57};

    reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = 8'h00; req1_data = 8'h00; TX_STATUS = 1'b1; err_clr = 1'b0;
    tick(2);
    chk("rst_tx_en", 32'(TX_EN), 32'd0);
    chk("rst_tx_data", 32'(TX_DATA), 32'h00);
    chk("rst_done_pulse", 32'(done_pulse), 32'd0);
    chk("rst_done_src", 32'(done_src), 32'd0);
    chk("rst_tx_err", 32'(tx_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready0", 32'(req0_ready), 32'd1);
    chk("rst_ready1", 32'(req1_ready), 32'd1);
    reset = 1'b0;
    tick(1);
    chk("post_rst_busy", 32'(busy), 32'd0);

    // Simultaneous first push after reset, then round-robin across both FIFOs
    model_on = 1'b1; frame_len = 10;
    en_q.delete(); en_cyc.delete(); dn_cyc.delete(); dn_src.delete();
    req0_valid = 1'b1; req0_data = 8'h01; req1_valid = 1'b1; req1_data = 8'h11;
    chk("sim_ready0", 32'(req0_ready), 32'd1);
    chk("sim_ready1", 32'(req1_ready), 32'd1);
    tick(1);
    req0_data = 8'h02; req1_data = 8'h12;
    chk("rr_ready0", 32'(req0_ready), 32'd1);
    chk("rr_ready1", 32'(req1_ready), 32'd1);
    tick(1);
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle(2000, ok);
    chk("rr_idle", 32'(ok), 32'd1);
    chk("rr_count", 32'(en_q.size()), 32'd4);
    chk("rr_done_count", 32'(dn_cyc.size()), 32'd4);
    for (int k = 0; k < 4 && k < en_q.size() && k < dn_src.size(); k++) begin
      chk("rr_order", 32'(en_q[k]), 32'(rr_exp[k]));
      chk("rr_src", 32'(dn_src[k]), 32'(k % 2));
      if (k < 3 && k + 1 < en_cyc.size())
        chk("rr_gap", 32'(en_cyc[k+1] - dn_cyc[k]), 32'(GAP_C + 2));
    end

    // Table of single frames: latency, data hold, source, timeout and error flag
    for (int v = 0; v < 6; v++) begin
      if (tbl[v].clr) begin
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("err_clr", 32'(tx_err), 32'd0);
      end
      model_on  = !tbl[v].tmo;
      frame_len = tbl[v].len;
      err_clr   = tbl[v].clr_hold;
      en0       = en_cnt;
      if (tbl[v].src) begin req1_valid = 1'b1; req1_data = tbl[v].data; end
      else            begin req0_valid = 1'b1; req0_data = tbl[v].data; end
      chk("vec_ready", 32'(tbl[v].src ? req1_ready : req0_ready), 32'd1);
      tick(1);
      req0_valid = 1'b0; req1_valid = 1'b0;
      chk("vec_en_n", 32'(TX_EN), 32'd0);
      tick(1);
      chk("vec_data_n1", 32'(TX_DATA), 32'(tbl[v].data));
      chk("vec_en_n1", 32'(TX_EN), 32'd0);
      tick(1);
      chk("vec_en_n2", 32'(TX_EN), 32'd1);
      c_en = cyc;
      tick(1);
      chk("vec_en_n3", 32'(TX_EN), 32'd0);
      wait_done(2000, ok);
      chk("vec_done", 32'(ok), 32'd1);
      if (tbl[v].tmo) chk("vec_tmo_cycles", 32'(cyc - c_en), 32'(ARM_T));
      chk("vec_done_src", 32'(done_src), 32'(tbl[v].src));
      chk("vec_data_hold", 32'(TX_DATA), 32'(tbl[v].data));
      chk("vec_tx_err", 32'(tx_err), 32'(tbl[v].exp_err));
      err_clr = 1'b0;
      chk("vec_busy_gap", 32'(busy), 32'd1);
      tick(1);
      chk("vec_done_once", 32'(done_pulse), 32'd0);
      chk("vec_data_gap", 32'(TX_DATA), 32'(tbl[v].data));
      tick(1);
      chk("vec_busy_end", 32'(busy), 32'd0);
      chk("vec_en_once", 32'(en_cnt - en0), 32'd1);
    end

    // Full FIFO while stalled in WAIT_DONE, then a push coinciding with a pop at count 3
    model_on = 1'b1; frame_len = 40;
    en_q.delete(); en_cyc.delete(); dn_cyc.delete(); dn_src.delete();
    push(1'b0, 8'h50, 10, ok);
    chk("ff_push_x", 32'(ok), 32'd1);
    for (int i = 0; i < 20 && TX_STATUS; i++) tick(1);
    chk("ff_stalled", 32'(TX_STATUS), 32'd0);
    tick(2);
    req0_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      req0_data = 8'h51 + 8'(k);
      chk("ff_ready_fill", 32'(req0_ready), 32'd1);
      tick(1);
    end
    req0_data = 8'h55;
    chk("ff_ready_full", 32'(req0_ready), 32'd0);
    tick(3);
    chk("ff_ready_held", 32'(req0_ready), 32'd0);
    push(1'b0, 8'h55, 300, ok);
    chk("ff_fifth_accepted", 32'(ok), 32'd1);
    chk("ff_fifth_after_pop", 32'(dn_cyc.size()), 32'd1);
    wait_done(300, ok);
    chk("ff_done_51", 32'(ok), 32'd1);
    wait_done(300, ok);
    chk("ff_done_52", 32'(ok), 32'd1);
    tick(2);
    req0_valid = 1'b1; req0_data = 8'h56;
    chk("ff_cnt3_ready", 32'(req0_ready), 32'd1);
    tick(1);
    req0_valid = 1'b0;
    chk("ff_cnt3_kept", 32'(req0_ready), 32'd1);
    req0_valid = 1'b1; req0_data = 8'h57;
    tick(1);
    req0_valid = 1'b0;
    chk("ff_cnt4_full", 32'(req0_ready), 32'd0);
    wait_idle(3000, ok);
    chk("ff_idle", 32'(ok), 32'd1);
    chk("ff_count", 32'(en_q.size()), 32'd8);
    for (int k = 0; k < 8 && k < en_q.size(); k++)
      chk("ff_order", 32'(en_q[k]), 32'(ff_exp[k]));

    // Reset while a frame is in WAIT_DONE with bytes queued
    model_on = 1'b0; TX_STATUS = 1'b1;
    push(1'b0, 8'h77, 10, ok);
    chk("mr_push", 32'(ok), 32'd1);
    for (int i = 0; i < 10 && !TX_EN; i++) tick(1);
    chk("mr_launch", 32'(TX_EN), 32'd1);
    tick(1);
    TX_STATUS = 1'b0;
    tick(2);
    push(1'b0, 8'h78, 10, ok);
    push(1'b0, 8'h79, 10, ok);
    push(1'b1, 8'h7A, 10, ok);
    chk("mr_busy_before", 32'(busy), 32'd1);
    chk("mr_data_before", 32'(TX_DATA), 32'h77);
    dn0 = dn_cyc.size();
    #2 reset = 1'b1;
    #1;
    chk("mr_tx_en", 32'(TX_EN), 32'd0);
    chk("mr_tx_data", 32'(TX_DATA), 32'h00);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_ready0", 32'(req0_ready), 32'd1);
    chk("mr_ready1", 32'(req1_ready), 32'd1);
    chk("mr_done_pulse", 32'(done_pulse), 32'd0);
    tick(2);
    reset = 1'b0; TX_STATUS = 1'b1;
    en0 = en_cnt;
    tick(20);
    chk("mr_no_launch", 32'(en_cnt - en0), 32'd0);
    chk("mr_no_done", 32'(dn_cyc.size() - dn0), 32'd0);
    chk("mr_busy_after", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
